// File: rtl/dline_pkg.sv
// Shared helpers for the variable delay line: width derivation and packed-bus channel slicing.
package dline_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Tap register width; never narrower than one bit.
    function automatic int tap_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // LSB of channel 'chan' inside a bus packed as {ch[N-1], ..., ch[1], ch[0]}.
    function automatic int chan_lsb(input int chan, input int data_w);
        return chan * data_w;
    endfunction

endpackage

// File: rtl/dline_chan.sv
// One channel of the delay line: DEPTH-stage shift array with a registered tap read.
module dline_chan
    import dline_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    input  logic [TAP_W-1:0]  tap_sel,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_reg[k] <= '0;
            end
        end else if (shift) begin
            stage_reg[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    // Output refreshes every cycle so it stays coherent across enable gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= stage_reg[tap_sel];
        end
    end

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel delay line with loadable, clamped tap and valid chain.
// Optional DLINE_TAP_GUARD_EN masks dout_vld for tap_q+1 shifts after a tap change.
module var_delay_line
    import dline_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 16,
    parameter int  CHANNELS = 1,
    parameter int  TAP_RST  = 0,
    localparam int TAP_W    = tap_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [CHANNELS*DATA_W-1:0]   din,
    input  logic                         din_vld,
    input  logic [TAP_W-1:0]             tap,
    input  logic                         tap_ld,
    output logic [CHANNELS*DATA_W-1:0]   dout,
    output logic                         dout_vld,
    output logic [TAP_W-1:0]             tap_q
);

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DEPTH - 1);

    logic             shift;
    logic [DEPTH-1:0] vld_reg;
    logic [TAP_W-1:0] tap_reg;
    logic [TAP_W-1:0] tap_clamped;
    logic             guard_ok;

    // Flush wins over enable: the concurrent sample is dropped.
    assign shift       = en & ~flush;
    assign tap_clamped = (tap > TAP_MAX) ? TAP_MAX : tap;
    assign tap_q       = tap_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
        end else if (flush) begin
            vld_reg <= '0;
        end else if (en) begin
            vld_reg <= {vld_reg[DEPTH-2:0], din_vld};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_reg <= TAP_W'(TAP_RST);
        end else if (tap_ld) begin
            tap_reg <= tap_clamped;
        end
    end

`ifdef DLINE_TAP_GUARD_EN
    logic [TAP_W:0] guard_cnt_reg;

    // Reloading the current tap is not a change and leaves the guard running down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_cnt_reg <= '0;
        end else if (tap_ld && (tap_clamped != tap_reg)) begin
            guard_cnt_reg <= (TAP_W+1)'(tap_clamped) + (TAP_W+1)'(1);
        end else if (en && (guard_cnt_reg != '0)) begin
            guard_cnt_reg <= guard_cnt_reg - (TAP_W+1)'(1);
        end
    end

    assign guard_ok = (guard_cnt_reg == '0);
`else
    assign guard_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= vld_reg[tap_reg] & guard_ok;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        dline_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .TAP_W  (TAP_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .shift   (shift),
            .din     (din[chan_lsb(gi, DATA_W) +: DATA_W]),
            .tap_sel (tap_reg),
            .dout    (dout[chan_lsb(gi, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_var_delay_line.sv
// Randomised bench for var_delay_line against a queue-based history model.
module tb_var_delay_line;
    import dline_pkg::*;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 12;
    localparam int CHANNELS = 3;
    localparam int TAP_RST  = 3;
    localparam int TAP_W    = tap_width(DEPTH);
    localparam int BW       = DATA_W * CHANNELS;

    logic             clk = 1'b0;
    logic             rst, en, flush, din_vld, tap_ld;
    logic [BW-1:0]    din, dout;
    logic             dout_vld;
    logic [TAP_W-1:0] tap, tap_q;

    var_delay_line #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TAP_RST(TAP_RST)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .tap(tap), .tap_ld(tap_ld), .dout(dout), .dout_vld(dout_vld), .tap_q(tap_q)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: history of accepted samples, newest at index 0.
    logic [BW-1:0] hist_data [$];
    bit            hist_vld  [$];
    int            m_tap;
    int            m_guard;
    logic [BW-1:0] exp_dout;
    bit            exp_vld;

    task automatic model_reset();
        hist_data.delete();
        hist_vld.delete();
        for (int i = 0; i < DEPTH; i++) begin
            hist_data.push_back('0);
            hist_vld.push_back(1'b0);
        end
        m_tap    = TAP_RST;
        m_guard  = 0;
        exp_dout = '0;
        exp_vld  = 1'b0;
    endtask

    task automatic model_edge();
        int req;
        exp_dout = hist_data[m_tap];
        exp_vld  = hist_vld[m_tap] && (m_guard == 0);
        if (flush) begin
            foreach (hist_vld[i]) hist_vld[i] = 1'b0;
        end else if (en) begin
            hist_data.push_front(din);
            hist_vld.push_front(din_vld);
            void'(hist_data.pop_back());
            void'(hist_vld.pop_back());
        end
        req = (int'(tap) > DEPTH - 1) ? DEPTH - 1 : int'(tap);
        if (tap_ld && req != m_tap) begin
`ifdef DLINE_TAP_GUARD_EN
            m_guard = req + 1;
`endif
            m_tap = req;
        end else if (en && m_guard > 0) begin
            m_guard--;
        end
    endtask

    task automatic compare(input string ph);
        for (int c = 0; c < CHANNELS; c++) begin
            check($sformatf("%s_dout_ch%0d", ph, c),
                  64'(dout[c*DATA_W +: DATA_W]), 64'(exp_dout[c*DATA_W +: DATA_W]));
        end
        check({ph, "_dout_vld"}, 64'(dout_vld), 64'(exp_vld));
        check({ph, "_tap_q"}, 64'(tap_q), 64'(m_tap));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare(ph);
    endtask

    function automatic logic [BW-1:0] rand_bus();
        return BW'({$urandom, $urandom});
    endfunction

    int zeros;

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_vld = 1'b0;
        tap = '0; tap_ld = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("reset");
        @(negedge clk) rst = 1'b0;

        // Tap 0, incrementing samples: each appears one edge after capture.
        en = 1'b1; din_vld = 1'b1; tap = '0; tap_ld = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            din = {CHANNELS{8'(i)}};
            step("seq");
            tap_ld = 1'b0;
            if (i >= 2) check("seq_value", 64'(dout[DATA_W-1:0]), 64'(i - 1));
        end

        // Tap 5 with continuous enable.
        tap = TAP_W'(5); tap_ld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = rand_bus();
            step("tap5");
            tap_ld = 1'b0;
        end

        // Out-of-range tap clamps to DEPTH-1.
        tap = TAP_W'(15); tap_ld = 1'b1;
        step("clamp");
        tap_ld = 1'b0;
        check("clamp_tap_q", 64'(tap_q), 64'(DEPTH - 1));
        for (int i = 0; i < 6; i++) begin
            din = rand_bus();
            step("clamp_run");
        end

        // Flush together with enable drops 0xAA and clears all valids.
        tap = TAP_W'(2); tap_ld = 1'b1;
        din = {CHANNELS{8'hAA}}; flush = 1'b1;
        step("flush");
        flush = 1'b0; tap_ld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = {CHANNELS{8'(i + 16)}};
            step("post_flush");
        end

        // Enable toggling with tap 3: output holds during gaps.
        tap = TAP_W'(3); tap_ld = 1'b1;
        for (int i = 0; i < 24; i++) begin
            en = i[0];
            din = rand_bus();
            step("en_gap");
            tap_ld = 1'b0;
        end

        // Guard: fill with valid samples at tap 2, then switch to 7.
        en = 1'b1; din_vld = 1'b1; tap = TAP_W'(2); tap_ld = 1'b1;
        for (int i = 0; i < 15; i++) begin
            din = rand_bus();
            step("guard_fill");
            tap_ld = 1'b0;
        end
        tap = TAP_W'(7); tap_ld = 1'b1;
        step("guard_load");
        tap_ld = 1'b0;
        zeros = 0;
        for (int i = 0; i < 12; i++) begin
            din = rand_bus();
            step("guard_run");
            if (!dout_vld) zeros++;
        end
`ifdef DLINE_TAP_GUARD_EN
        check("guard_masked_cycles", 64'(zeros), 64'(8));
`else
        check("guard_masked_cycles", 64'(zeros), 64'(0));
`endif
        tap_ld = 1'b1;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            din = rand_bus();
            step("guard_same");
            tap_ld = 1'b0;
            if (!dout_vld) zeros++;
        end
        check("guard_same_tap", 64'(zeros), 64'(0));

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            tap_ld  = ($urandom_range(0, 9) == 0);
            tap     = TAP_W'($urandom_range(0, (1 << TAP_W) - 1));
            din_vld = ($urandom_range(0, 3) != 0);
            din     = rand_bus();
            step("rand");
        end

        // Asynchronous reset mid-stream, then restart.
        en = 1'b1; flush = 1'b0; tap_ld = 1'b0; din_vld = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare("rst_mid");
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din     = rand_bus();
            din_vld = ($urandom_range(0, 3) != 0);
            tap_ld  = ($urandom_range(0, 7) == 0);
            tap     = TAP_W'($urandom_range(0, DEPTH - 1));
            step("restart");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
